// File: rtl/fetch_stage_pkg.sv
// Shared CPU constants for the front end: boot vector, NOP encoding, PC increment.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INST             = 32'h0000_0000;
  localparam logic [31:0] INST_BYTES           = 32'd4;

  function automatic logic [31:0] pc_incr(input logic [31:0] pc);
    return pc + INST_BYTES;
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: pre-IF issues next_pc to the SRAM, IF presents pc/inst one cycle later.
// One instruction per cycle; a decode stall freezes IF, buffers the word and blocks new requests.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        id_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        if_to_id_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  logic        resetn_released;
  logic        if_valid;
  logic        buf_valid;
  logic        redirect_pending;
  logic [31:0] pc;
  logic [31:0] inst_buf;
  logic [31:0] redirect_target;
  logic [31:0] next_pc;
  logic        if_allowin;
  logic        if_accept;

  assign if_allowin   = !if_valid || id_allowin;
  assign if_accept    = if_valid && id_allowin;
  assign inst_sram_en = resetn_released && if_allowin;

  always_comb begin
    next_pc = pc_incr(pc);
    if (br_taken) begin
      next_pc = br_target;
    end else if (redirect_pending) begin
      next_pc = redirect_target;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resetn_released  <= 1'b0;
      pc               <= RESET_VECTOR - INST_BYTES;
      if_valid         <= 1'b0;
      buf_valid        <= 1'b0;
      inst_buf         <= NOP_INST;
      redirect_pending <= 1'b0;
      redirect_target  <= 32'h0;
    end else begin
      resetn_released <= 1'b1;

      if (inst_sram_en) begin
        pc       <= next_pc;
        if_valid <= 1'b1;
      end else if (if_accept) begin
        if_valid <= 1'b0;
      end

      // SRAM data is only valid for one cycle, so hold it once decode stalls.
      if (if_accept) begin
        buf_valid <= 1'b0;
      end else if (if_valid && !buf_valid) begin
        buf_valid <= 1'b1;
        inst_buf  <= inst_sram_rdata;
      end

      if (br_taken && !inst_sram_en) begin
        redirect_pending <= 1'b1;
        redirect_target  <= br_target;
      end else if (inst_sram_en) begin
        redirect_pending <= 1'b0;
      end
    end
  end

  assign if_to_id_valid  = if_valid;
  assign if_pc           = pc;
  assign if_inst         = buf_valid ? inst_buf : inst_sram_rdata;
  assign inst_sram_addr  = next_pc;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'h0;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations plus a randomized run
module tb_fetch_stage;

  localparam logic [31:0] RV = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        id_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        if_to_id_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = 32'hDEADBEEF;

  int checks = 0;
  int failures = 0;

  fetch_stage #(.RESET_VECTOR(RV)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .id_allowin      (id_allowin),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .if_to_id_valid  (if_to_id_valid),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  // Synchronous SRAM: word valid only the cycle after an enabled read, garbage otherwise.
  always @(posedge clk) begin
    inst_sram_rdata <= inst_sram_en ? mem(inst_sram_addr) : 32'hDEADBEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-stream model: which address must be fetched next, and what IF presents.
  logic        m_rel = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_nf = RV;

  always @(negedge clk) begin
    logic        en_e;
    logic [31:0] addr_e;
    if (!resetn) begin
      chk("m_rst_en", {31'h0, inst_sram_en}, 32'h0);
      chk("m_rst_vld", {31'h0, if_to_id_valid}, 32'h0);
      m_rel   = 1'b0;
      m_valid = 1'b0;
      m_nf    = RV;
    end else begin
      en_e   = m_rel && (!m_valid || id_allowin);
      addr_e = br_taken ? br_target : m_nf;
      chk("m_en", {31'h0, inst_sram_en}, {31'h0, en_e});
      chk("m_wen", {28'h0, inst_sram_wen}, 32'h0);
      chk("m_wdata", inst_sram_wdata, 32'h0);
      if (en_e) chk("m_addr", inst_sram_addr, addr_e);
      chk("m_vld", {31'h0, if_to_id_valid}, {31'h0, m_valid});
      if (m_valid) begin
        chk("m_pc", if_pc, m_pc);
        chk("m_inst", if_inst, mem(m_pc));
      end
      if (en_e) begin
        m_pc    = addr_e;
        m_nf    = addr_e + 32'd4;
        m_valid = 1'b1;
      end else begin
        if (m_valid && id_allowin) m_valid = 1'b0;
        if (br_taken) m_nf = br_target;
      end
      m_rel = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_en();
    int n = 0;
    @(negedge clk);
    while (!inst_sram_en && n < 5) begin
      @(negedge clk);
      n++;
    end
    chk("wait_en", {31'h0, inst_sram_en}, 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; id_allowin = 1'b1; br_taken = 1'b0; br_target = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_en", {31'h0, inst_sram_en}, 32'h0);
    chk("rst_vld", {31'h0, if_to_id_valid}, 32'h0);
    chk("rst_pc", if_pc, 32'hBFBF_FFFC);

    // Boot fetch stream
    tick(); resetn = 1'b1;
    wait_en();
    chk("boot_a0", inst_sram_addr, 32'hBFC0_0000);
    tick(); @(negedge clk);
    chk("boot_a1", inst_sram_addr, 32'hBFC0_0004);
    chk("boot_pc0", if_pc, 32'hBFC0_0000);
    chk("boot_vld", {31'h0, if_to_id_valid}, 32'h1);

    // Decode stall for three cycles with 0xBFC00004 in IF
    tick(); id_allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_en", {31'h0, inst_sram_en}, 32'h0);
      chk("stall_pc", if_pc, 32'hBFC0_0004);
      chk("stall_inst", if_inst, mem(32'hBFC0_0004));
      tick();
    end
    id_allowin = 1'b1;
    @(negedge clk);
    chk("resume_addr", inst_sram_addr, 32'hBFC0_0008);
    chk("resume_inst", if_inst, mem(32'hBFC0_0004));

    // Branch with delay slot 0xBFC00008 in IF
    tick(); br_taken = 1'b1; br_target = 32'hBFC0_0100;
    @(negedge clk);
    chk("br_slot_pc", if_pc, 32'hBFC0_0008);
    chk("br_addr", inst_sram_addr, 32'hBFC0_0100);
    tick(); br_taken = 1'b0;
    @(negedge clk);
    chk("br_tgt_pc", if_pc, 32'hBFC0_0100);
    chk("br_tgt_inst", if_inst, mem(32'hBFC0_0100));
    chk("br_next_addr", inst_sram_addr, 32'hBFC0_0104);

    // Branch while stalled: redirect held until decode frees up
    tick(); id_allowin = 1'b0;
    @(negedge clk);
    chk("pend_en0", {31'h0, inst_sram_en}, 32'h0);
    tick(); br_taken = 1'b1; br_target = 32'hBFC0_0200;
    @(negedge clk);
    chk("pend_en1", {31'h0, inst_sram_en}, 32'h0);
    tick(); br_taken = 1'b0;
    @(negedge clk);
    chk("pend_en2", {31'h0, inst_sram_en}, 32'h0);
    chk("pend_pc", if_pc, 32'hBFC0_0104);
    tick(); id_allowin = 1'b1;
    @(negedge clk);
    chk("pend_addr", inst_sram_addr, 32'hBFC0_0200);
    tick(); @(negedge clk);
    chk("pend_pc2", if_pc, 32'hBFC0_0200);
    chk("pend_clr_addr", inst_sram_addr, 32'hBFC0_0204);

    // PC wrap
    tick(); br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
    @(negedge clk);
    chk("wrap_a0", inst_sram_addr, 32'hFFFF_FFFC);
    tick(); br_taken = 1'b0;
    @(negedge clk);
    chk("wrap_a1", inst_sram_addr, 32'h0000_0000);
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_inst", if_inst, mem(32'hFFFF_FFFC));

    // Reset during a stall with a pending redirect
    tick(); id_allowin = 1'b0;
    @(negedge clk);
    chk("mrst_stall_en", {31'h0, inst_sram_en}, 32'h0);
    tick(); br_taken = 1'b1; br_target = 32'hBFC0_0300;
    tick(); br_taken = 1'b0; resetn = 1'b0;
    @(negedge clk);
    chk("mrst_en", {31'h0, inst_sram_en}, 32'h0);
    chk("mrst_vld", {31'h0, if_to_id_valid}, 32'h0);
    chk("mrst_pc", if_pc, 32'hBFBF_FFFC);
    tick(); resetn = 1'b1; id_allowin = 1'b1;
    wait_en();
    chk("mrst_a0", inst_sram_addr, 32'hBFC0_0000);
    tick(); @(negedge clk);
    chk("mrst_pc0", if_pc, 32'hBFC0_0000);
    chk("mrst_a1", inst_sram_addr, 32'hBFC0_0004);

    // Randomized traffic, checked by the model
    for (int i = 0; i < 3000; i++) begin
      tick();
      resetn     = ($urandom_range(0, 199) != 0);
      id_allowin = ($urandom_range(0, 9) < 7);
      br_taken   = resetn && ($urandom_range(0, 9) == 0);
      br_target  = {$urandom(), 2'b00} >> 0;
      br_target[1:0] = 2'b00;
    end
    tick(); resetn = 1'b1; br_taken = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'hBFC0_0000, address of the first fetched instruction.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port id_allowin  input  1  decode stage can accept an instruction this cycle.
REQ-005 SHALL have port br_taken  input  1  decode redirect request, one-cycle pulse, valid only when decode holds a valid branch.
REQ-006 SHALL have port br_target  input  32  redirect address, sampled with br_taken.
REQ-007 SHALL have port if_to_id_valid  output  1  fetched instruction presented to decode.
REQ-008 SHALL have port if_pc  output  32  PC of the presented instruction.
REQ-009 SHALL have port if_inst  output  32  presented instruction word.
REQ-010 SHALL have port inst_sram_en  output  1  SRAM read enable.
REQ-011 SHALL have port inst_sram_wen  output  4  constant 4'b0000.
REQ-012 SHALL have port inst_sram_addr  output  32  SRAM read address, equal to next_pc.
REQ-013 SHALL have port inst_sram_wdata  output  32  constant 32'h0.
REQ-014 SHALL have port inst_sram_rdata  input  32  SRAM read data, valid exactly one cycle after an enabled read.

Function
REQ-015 SHALL model two sub-stages: pre-IF (next_pc generation, SRAM request) and IF (pc register, if_valid, response).
REQ-016 SHALL compute if_allowin = !if_valid || id_allowin; IF ready_go SHALL be constant 1.
REQ-017 SHALL drive inst_sram_en = resetn_released && if_allowin; no request SHALL be issued while IF is stalled.
REQ-018 SHALL select next_pc with priority: br_taken ? br_target : redirect_pending ? redirect_target : pc + 4; the add SHALL wrap modulo 2^32.
REQ-019 SHALL, on an enabled request, load pc <= next_pc and set if_valid <= 1 at the next edge; if_to_id_valid = if_valid.
REQ-020 SHALL clear if_valid when the IF instruction is accepted (if_valid && id_allowin) and no new request is issued.
REQ-021 SHALL capture inst_sram_rdata into inst_buf and set buf_valid on the first stalled cycle (if_valid && !id_allowin && !buf_valid).
REQ-022 SHALL drive if_inst = buf_valid ? inst_buf : inst_sram_rdata; buf_valid SHALL clear on acceptance.
REQ-023 SHALL honour branch delay slot: the instruction in IF when br_taken fires is kept and delivered; the target is fetched next.
REQ-024 SHALL, when br_taken arrives while IF cannot issue (!if_allowin), latch redirect_pending=1, redirect_target=br_target, and use it on the next issued request, then clear it.
REQ-025 SHALL give a later br_taken priority over an existing redirect_pending (target overwritten).
REQ-026 SHALL produce 1-cycle fetch latency: address issued cycle N, if_to_id_valid with that PC/instruction from cycle N+1.
REQ-027 SHALL sustain one instruction per cycle when id_allowin stays 1.

Reset
REQ-028 SHALL, while resetn=0: pc = RESET_VECTOR-4, if_valid=0, buf_valid=0, redirect_pending=0, inst_buf=0, redirect_target=0, inst_sram_en=0.
REQ-029 SHALL issue the first request to RESET_VECTOR in the first cycle after resetn deasserts (resetn_released registered).
REQ-030 SHALL, on reset assertion mid-operation, discard any in-flight response, buffer and pending redirect immediately.

Structure
REQ-031 SHALL place RESET_VECTOR default and the NOP encoding 32'h0 in the shared CPU package.
REQ-032 SHALL be a single module with no sub-modules; pipeline registers are inline.

Verification
REQ-033 Reset release, id_allowin=1 -> addresses 0xBFC00000, 0xBFC00004, 0xBFC00008 on consecutive cycles; if_pc follows one cycle later.
REQ-034 id_allowin=0 for 3 cycles with if_pc=0xBFC00004, rdata then changed to 0xDEADBEEF -> if_inst holds the word returned for 0xBFC00004, inst_sram_en=0, resumes at 0xBFC00008.
REQ-035 br_taken with br_target=0xBFC00100 while IF holds 0xBFC00008 -> 0xBFC00008 (delay slot) delivered, next if_pc=0xBFC00100.
REQ-036 br_taken (target 0xBFC00200) during a stall -> no request until id_allowin=1, then address 0xBFC00200, pending cleared.
REQ-037 pc=0xFFFFFFFC, no branch -> next address 0x00000000.
REQ-038 resetn pulled low during a stall with redirect_pending=1 -> all state cleared; restart fetches 0xBFC00000.
